// File: rtl/cic_comb_decimator_if.sv
// Sample bus for the CIC comb decimator: integrated input samples with their
// strobe, and decimated output samples with their strobe.
//   inp_samp_data / inp_samp_str : integrated sample and its valid strobe
//   out_samp_data / out_samp_str : decimated, differentiated sample and strobe
// master: the side feeding samples in (integrator cascade or bench)
// slave : the comb decimator
interface cic_comb_decimator_if #(
    parameter int unsigned DATA_WIDTH_INP = 8,
    parameter int unsigned DATA_WIDTH_OUT = 8
);
    logic signed [DATA_WIDTH_INP-1:0] inp_samp_data;
    logic                             inp_samp_str;
    logic signed [DATA_WIDTH_OUT-1:0] out_samp_data;
    logic                             out_samp_str;

    modport master (
        output inp_samp_data,
        output inp_samp_str,
        input  out_samp_data,
        input  out_samp_str
    );

    modport slave (
        input  inp_samp_data,
        input  inp_samp_str,
        output out_samp_data,
        output out_samp_str
    );
endinterface

// File: rtl/cic_comb_decimator.sv
// Decimating comb section of a CIC decimator. Keeps every DEC_RATE-th strobed
// input sample, then runs it through STAGES comb stages y = x - x[n-DIFF_DELAY]
// (n counts decimated samples) in modular DATA_WIDTH_INP arithmetic.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of cic_comb_decimator_if (input sample/strobe in,
//           decimated sample/strobe out, registered)
// Optional feature: define CIC_COMB_ROUND_EN to round half-up (with positive
// saturation) instead of truncating to DATA_WIDTH_OUT bits.
module cic_comb_decimator #(
    parameter int unsigned DATA_WIDTH_INP = 8,
    parameter int unsigned DATA_WIDTH_OUT = 8,
    parameter int unsigned STAGES         = 3,
    parameter int unsigned DIFF_DELAY     = 1,
    parameter int unsigned DEC_RATE       = 4
) (
    input logic                 clk,
    input logic                 reset,
    cic_comb_decimator_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEC_RATE);
    localparam int unsigned SHIFT = DATA_WIDTH_INP - DATA_WIDTH_OUT;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_RATE - 1);

    typedef logic signed [DATA_WIDTH_INP-1:0] samp_t;
    typedef logic signed [DATA_WIDTH_OUT-1:0] out_t;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    samp_t             dec_data_q, dec_data_d;
    logic              dec_str_q, dec_str_d;
    samp_t             dly_q [STAGES][DIFF_DELAY];
    samp_t             dly_d [STAGES][DIFF_DELAY];
    samp_t             res_q [STAGES];
    samp_t             res_d [STAGES];
    logic [STAGES-1:0] str_q, str_d;
    out_t              out_data_q, out_data_d;
    logic              out_str_q, out_str_d;

    samp_t             stage_in_c [STAGES];
    logic [STAGES-1:0] stage_in_str_c;
    out_t              quant_c;

    // Decimation: keep the sample on every DEC_RATE-th input strobe.
    always_comb begin
        cnt_d      = cnt_q;
        dec_data_d = dec_data_q;
        dec_str_d  = 1'b0;
        if (bus.inp_samp_str) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                dec_data_d = bus.inp_samp_data;
                dec_str_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Comb chain: each stage advances only on its incoming strobe; wrap-around
    // subtraction is intentional so integrator overflow cancels out.
    always_comb begin
        stage_in_c[0]     = dec_data_q;
        stage_in_str_c[0] = dec_str_q;
        for (int k = 1; k < int'(STAGES); k++) begin
            stage_in_c[k]     = res_q[k-1];
            stage_in_str_c[k] = str_q[k-1];
        end
        dly_d = dly_q;
        res_d = res_q;
        str_d = stage_in_str_c;
        for (int k = 0; k < int'(STAGES); k++) begin
            if (stage_in_str_c[k]) begin
                res_d[k]    = stage_in_c[k] - dly_q[k][DIFF_DELAY-1];
                dly_d[k][0] = stage_in_c[k];
                for (int j = 1; j < int'(DIFF_DELAY); j++) begin
                    dly_d[k][j] = dly_q[k][j-1];
                end
            end
        end
    end

    // Output quantization of the last stage result.
    generate
        if (SHIFT == 0) begin : g_pass
            assign quant_c = res_q[STAGES-1];
        end else begin : g_quant
`ifdef CIC_COMB_ROUND_EN
            localparam logic [DATA_WIDTH_INP:0] HALF = (DATA_WIDTH_INP + 1)'(1) << (SHIFT - 1);
            logic [DATA_WIDTH_INP:0] sum_c;
            logic [DATA_WIDTH_OUT:0] shr_c;
            assign sum_c = {res_q[STAGES-1][DATA_WIDTH_INP-1], res_q[STAGES-1]} + HALF;
            assign shr_c = sum_c[DATA_WIDTH_INP:SHIFT];
            // Only a positive overflow is possible: the half-LSB add never goes down.
            assign quant_c = (shr_c[DATA_WIDTH_OUT] != shr_c[DATA_WIDTH_OUT-1])
                           ? {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}}
                           : shr_c[DATA_WIDTH_OUT-1:0];
`else
            assign quant_c = res_q[STAGES-1][DATA_WIDTH_INP-1:SHIFT];
`endif
        end
    endgenerate

    // Output register holds its value between strobes.
    always_comb begin
        out_data_d = out_data_q;
        out_str_d  = str_q[STAGES-1];
        if (str_q[STAGES-1]) begin
            out_data_d = quant_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            dec_data_q <= '0;
            dec_str_q  <= 1'b0;
            str_q      <= '0;
            out_data_q <= '0;
            out_str_q  <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                res_q[k] <= '0;
                for (int j = 0; j < int'(DIFF_DELAY); j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else begin
            cnt_q      <= cnt_d;
            dec_data_q <= dec_data_d;
            dec_str_q  <= dec_str_d;
            str_q      <= str_d;
            out_data_q <= out_data_d;
            out_str_q  <= out_str_d;
            res_q      <= res_d;
            dly_q      <= dly_d;
        end
    end

    assign bus.out_samp_data = out_data_q;
    assign bus.out_samp_str  = out_str_q;
endmodule

// File: tb/tb_cic_comb_decimator.sv
// Scoreboard bench for cic_comb_decimator. Four instances cover the configs:
//   0: N=1 M=1 R=4 8/8   1: N=1 M=1 R=2 8/8
//   2: N=2 M=2 R=2 8/8   3: N=1 M=1 R=2 8/4
// Expected samples are computed from the decimated history when the R-th
// strobe is driven and checked (value and arrival cycle) when strobes appear.
module tb_cic_comb_decimator;
    localparam int P_N [4] = '{1, 1, 2, 1};
    localparam int P_M [4] = '{1, 1, 2, 1};
    localparam int P_R [4] = '{4, 2, 2, 2};
    localparam int P_O [4] = '{8, 8, 8, 4};

    typedef struct {
        int dut;
        int val;
        int cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    logic rst_seen;
    int   total;
    int   bad;
    exp_t exp_q[$];
    int   hist[$];
    int   cnt_m;
    int   out_val [4];
    logic out_str [4];
    int   last_val [4];

    cic_comb_decimator_if #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8)) if_a ();
    cic_comb_decimator_if #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8)) if_b ();
    cic_comb_decimator_if #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8)) if_c ();
    cic_comb_decimator_if #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(4)) if_d ();

    cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1),
                         .DIFF_DELAY(1), .DEC_RATE(4))
        u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
    cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1),
                         .DIFF_DELAY(1), .DEC_RATE(2))
        u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
    cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(2),
                         .DIFF_DELAY(2), .DEC_RATE(2))
        u_dut_c (.clk(clk), .reset(reset), .bus(if_c));
    cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(4), .STAGES(1),
                         .DIFF_DELAY(1), .DEC_RATE(2))
        u_dut_d (.clk(clk), .reset(reset), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    always_comb begin
        out_val[0] = int'(if_a.out_samp_data);
        out_val[1] = int'(if_b.out_samp_data);
        out_val[2] = int'(if_c.out_samp_data);
        out_val[3] = int'(if_d.out_samp_data);
        out_str[0] = if_a.out_samp_str;
        out_str[1] = if_b.out_samp_str;
        out_str[2] = if_c.out_samp_str;
        out_str[3] = if_d.out_samp_str;
    end

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Comb response of the decimated history: s stages of x[n] - x[n-m].
    function automatic int comb(input int n, input int s, input int m);
        if (n < 0) return 0;
        if (s == 0) return hist[n];
        return comb(n, s - 1, m) - comb(n - m, s - 1, m);
    endfunction

    function automatic int quant(input int d, input int y);
        int s;
        int r;
        s = 8 - P_O[d];
        if (s == 0) return y;
`ifdef CIC_COMB_ROUND_EN
        r = (y + (1 << (s - 1))) >>> s;
        if (r > (1 << (P_O[d] - 1)) - 1) r = (1 << (P_O[d] - 1)) - 1;
`else
        r = y >>> s;
`endif
        return r;
    endfunction

    task automatic model_push(input int d, input int val);
        int y;
        exp_t e;
        cnt_m++;
        if (cnt_m == P_R[d]) begin
            cnt_m = 0;
            hist.push_back(val & 255);
            y = comb(hist.size() - 1, P_N[d], P_M[d]) & 255;
            if (y > 127) y -= 256;
            e.dut = d;
            e.val = quant(d, y);
            e.cyc = cyc + P_N[d] + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_inputs(input int d, input int val, input bit str);
        if_a.inp_samp_data = 8'(val);
        if_b.inp_samp_data = 8'(val);
        if_c.inp_samp_data = 8'(val);
        if_d.inp_samp_data = 8'(val);
        if_a.inp_samp_str  = str && (d == 0);
        if_b.inp_samp_str  = str && (d == 1);
        if_c.inp_samp_str  = str && (d == 2);
        if_d.inp_samp_str  = str && (d == 3);
    endtask

    // One clock of stimulus for instance d.
    task automatic step(input int d, input int val, input bit str);
        @(negedge clk);
        set_inputs(d, val, str);
        if (str) model_push(d, val);
    endtask

    // One-cycle reset, optionally with a (discarded) strobe in the same cycle.
    task automatic apply_reset(input int d, input bit with_str, input int val);
        @(negedge clk);
        reset = 1'b1;
        set_inputs(d, val, with_str);
        @(negedge clk);
        reset = 1'b0;
        set_inputs(d, 0, 1'b0);
        exp_q.delete();
        hist.delete();
        cnt_m = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_str%0d", i), int'(out_str[i]), 0);
            check($sformatf("reset_data%0d", i), out_val[i], 0);
        end
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (out_str[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("spurious_str%0d", d), int'(out_str[d]), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("dut_id%0d", d), d, e.dut);
                    check($sformatf("data%0d", d), out_val[d], e.val);
                    check($sformatf("latency%0d", d), cyc, e.cyc);
                end
            end else if (rst_seen === 1'b0 && out_val[d] !== last_val[d]) begin
                check($sformatf("hold%0d", d), out_val[d], last_val[d]);
            end
            last_val[d] = out_val[d];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        cnt_m = 0;
        reset = 1'b1;
        set_inputs(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        apply_reset(0, 1'b0, 0);

        // Constant step: back-to-back ramp 1..12 gives 4, 4, 4.
        for (int v = 1; v <= 12; v++) step(0, v, 1'b1);
        step(0, 0, 1'b0);
        wait_drain(20);

        // Gapped strobes: every 3rd cycle, then random gaps.
        apply_reset(0, 1'b0, 0);
        for (int v = 1; v <= 12; v++) begin
            step(0, v, 1'b1);
            repeat (2) step(0, 0, 1'b0);
        end
        wait_drain(20);
        apply_reset(0, 1'b0, 0);
        for (int v = 1; v <= 12; v++) begin
            step(0, v, 1'b1);
            repeat ($urandom_range(0, 5)) step(0, 0, 1'b0);
        end
        wait_drain(20);

        // Reset mid-operation: in-flight sample after the 4th strobe is killed.
        apply_reset(0, 1'b0, 0);
        for (int v = 1; v <= 4; v++) step(0, v, 1'b1);
        apply_reset(0, 1'b0, 0);
        repeat (6) step(0, 0, 1'b0);
        // Six strobes, then reset together with a strobe; ramp restarts from 1.
        for (int v = 1; v <= 6; v++) step(0, v, 1'b1);
        apply_reset(0, 1'b1, 99);
        for (int v = 1; v <= 12; v++) step(0, v, 1'b1);
        step(0, 0, 1'b0);
        wait_drain(20);

        // Modular wrap: decimated 120 then -120 gives 120 then 16.
        apply_reset(1, 1'b0, 0);
        step(1, 0, 1'b1);
        step(1, 120, 1'b1);
        step(1, 0, 1'b1);
        step(1, 136, 1'b1);
        step(1, 0, 1'b0);
        wait_drain(20);

        // Multi-stage impulse: 5,0,0,0,0,0 gives 5,0,-10,0,5,0.
        apply_reset(2, 1'b0, 0);
        step(2, 0, 1'b1);
        step(2, 5, 1'b1);
        for (int i = 0; i < 10; i++) step(2, 0, 1'b1);
        step(2, 0, 1'b0);
        wait_drain(20);
        for (int i = 0; i < 24; i++) begin
            step(2, int'($urandom_range(0, 255)), 1'b1);
            repeat ($urandom_range(0, 2)) step(2, 0, 1'b0);
        end
        step(2, 0, 1'b0);
        wait_drain(20);

        // Output quantization: stage results 24 and 124, then random data.
        apply_reset(3, 1'b0, 0);
        step(3, 0, 1'b1);
        step(3, 24, 1'b1);
        step(3, 0, 1'b1);
        step(3, 148, 1'b1);
        step(3, 0, 1'b0);
        wait_drain(20);
        for (int i = 0; i < 24; i++) begin
            step(3, int'($urandom_range(0, 255)), 1'b1);
            repeat ($urandom_range(0, 2)) step(3, 0, 1'b0);
        end
        step(3, 0, 1'b0);
        wait_drain(20);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cic_comb_decimator.md
# cic_comb_decimator

Decimating comb section of the CIC decimator. It sits directly after the integrator cascade. It downsamples the integrated stream by a fixed rate R, then runs it through N cascaded comb (differentiator) stages with differential delay M. The result is a strobe-qualified output at the decimated rate.

## Interface
- `DATA_WIDTH_INP`, default 8: input and internal comb width; must equal the integrator output width.
- `DATA_WIDTH_OUT`, default 8: output width; must be ≤ `DATA_WIDTH_INP`.
- `STAGES`, default 3: number of comb stages N, ≥ 1.
- `DIFF_DELAY`, default 1: differential delay M, 1 or 2.
- `DEC_RATE`, default 4: decimation rate R, ≥ 2.
- `clk`  input  1: single clock; all logic on its rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `inp_samp_data`  input  signed `DATA_WIDTH_INP`: integrated sample.
- `inp_samp_str`  input  1: input strobe; data is valid in any cycle where it is high.
- `out_samp_data`  output  signed `DATA_WIDTH_OUT`: decimated, differentiated sample.
- `out_samp_str`  output  1: one-cycle output strobe.

## Operation
- **Decimation counter** `cnt`, range 0..R-1.
  - Increments only on `inp_samp_str`.
  - On a strobe with `cnt == R-1`: the sample is captured into the decimation register, a decimated strobe is raised for one cycle, and `cnt` wraps to 0.
  - All other input samples are discarded.
- **Comb stage k** (k = 1..N): `y_k = x_k - x_k[n-M]`. Here n indexes decimated samples, not clocks.
  - Each stage holds an M-deep delay line and a result register.
  - Each stage advances only when its incoming strobe is high.
  - Its strobe output is the registered incoming strobe.
  - Stages hold their value between strobes.
- **Arithmetic**
  - All comb arithmetic is `DATA_WIDTH_INP` two's complement with modular wrap-around.
  - Carries are discarded and overflow is not detected. This is required for CIC correctness when the integrators have wrapped.
- **Output**
  - `out_samp_data` = top `DATA_WIDTH_OUT` bits of the stage-N result (truncation), unless the rounding feature below is enabled.
- **Reset**
  - On `reset` high, the following clear to 0 on the next edge: `cnt`, the decimation register, all delay lines, all stage registers, all strobes, and `out_samp_str`/`out_samp_data`.
  - Reset mid-operation discards all in-flight samples and strobes.
  - The first strobe after reset is counted as `cnt` = 0.

## Timing
- Input strobes may arrive back-to-back (every cycle) or with arbitrary gaps. There is no backpressure and no sample is ever dropped beyond decimation.
- Latency: `out_samp_str` goes high exactly N+1 cycles after the edge that sampled the R-th input strobe.
  - 1 cycle for the decimation register.
  - 1 cycle per comb stage.
- `out_samp_str` is high for exactly one cycle per decimated sample. Its period follows the R-th-input-strobe spacing.
- `out_samp_data` is stable from the strobe cycle until the next output strobe.
- Reset asserted in the same cycle as `inp_samp_str`: reset wins and the sample is discarded.

## Configuration
- Macro `CIC_COMB_ROUND_EN` selects the output quantization.
- **Defined:** the final output register computes `(y_N + 2^(DATA_WIDTH_INP-DATA_WIDTH_OUT-1)) >>> (DATA_WIDTH_INP-DATA_WIDTH_OUT)`.
  - This is round-half-up.
  - A positive overflow from the rounding add saturates to the maximum positive `DATA_WIDTH_OUT` value.
  - Latency is unchanged.
  - If `DATA_WIDTH_INP == DATA_WIDTH_OUT`, the output passes through unchanged.
- **Undefined:** plain truncation to the top `DATA_WIDTH_OUT` bits.

## Test plan
1. **Constant step.** N=1, M=1, R=4, widths 8/8. Drive back-to-back strobes with inputs 1,2,3,…,12.
   - Output strobes carry 4, 4, 4.
   - The first output strobe occurs 2 cycles after the edge that sampled input 4.
2. **Modular wrap.** N=1, M=1, R=2, widths 8/8. Decimated inputs are 120 then -120 (raw 136).
   - Second output = 16; no saturation, no error.
3. **Gapped strobes.** Same config as test 1, with strobes every 3rd cycle and then random gaps.
   - Output values are identical to test 1.
   - Each output strobe is 2 cycles after the 4th, 8th and 12th strobed input.
4. **Multi-stage impulse.** N=2, M=2, R=2. Decimated sequence 5,0,0,0,0,0.
   - Output = 5, 0, -10, 0, 5, 0.
   - Latency is 3 cycles.
5. **Reset mid-operation.** Config of test 1. Assert `reset` for 1 cycle after 6 input strobes, then restart the ramp from 1.
   - No output strobe appears from pre-reset data.
   - Outputs are again 4, 4, 4 with `cnt` restarted.
6. **Rounding.** `CIC_COMB_ROUND_EN` defined, N=1, M=1, R=2, widths 8/4.
   - Stage result 24 → output 2; without the macro → 1.
   - Stage result 124 → output saturates to 7.
